// File: rtl/imm_extend_pipe_pkg.sv
// rtl/imm_extend_pipe_pkg.sv - immediate format codes and the combinational extend function
package imm_pkg;

    typedef enum logic [2:0] {
        IMM_I     = 3'd0,
        IMM_S     = 3'd1,
        IMM_B     = 3'd2,
        IMM_J     = 3'd3,
        IMM_U     = 3'd4,
        IMM_SHAMT = 3'd5,
        IMM_ZIMM  = 3'd6,
        IMM_RSVD  = 3'd7
    } imm_src_e;

    // instr holds instruction bits [31:7], so instruction bit n is instr[n-7].
    // Result is {err, imm[63:0]}; callers keep the low XLEN bits.
    function automatic logic [64:0] imm_extend(input logic [24:0] instr,
                                               input imm_src_e   src,
                                               input int         xlen);
        logic [51:0] s;
        logic [63:0] imm;
        logic        err;
        s   = {52{instr[24]}};
        imm = '0;
        err = 1'b0;
        case (src)
            IMM_I:     imm = {s, instr[24:13]};
            IMM_S:     imm = {s, instr[24:18], instr[4:0]};
            IMM_B:     imm = {s, instr[0], instr[23:18], instr[4:1], 1'b0};
            IMM_J:     imm = {s[43:0], instr[12:5], instr[13], instr[23:14], 1'b0};
            IMM_U:     imm = {s[31:0], instr[24:5], 12'b0};
            IMM_SHAMT: imm = (xlen == 64) ? {58'b0, instr[18:13]} : {59'b0, instr[17:13]};
            IMM_ZIMM:  imm = {59'b0, instr[12:8]};
            default:   err = 1'b1;
        endcase
        return {err, imm};
    endfunction

endpackage

// File: rtl/imm_extend_pipe_skid.sv
// rtl/imm_extend_pipe_skid.sv - 2-entry skid buffer (imm_skid_buf) with registered in_ready
module imm_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [W-1:0] out_q, out_d, skid_q, skid_d;
    logic         out_v, out_v_d, skid_v, skid_v_d, rdy_q;
    logic         in_fire, load_out;

    assign in_fire  = in_valid && rdy_q;
    assign load_out = !out_v || out_ready;

    // Skid only fills while the output register is stalled; it drains first when it frees up.
    always_comb begin
        out_d    = out_q;
        out_v_d  = out_v;
        skid_d   = skid_q;
        skid_v_d = skid_v;
        if (load_out) begin
            if (skid_v) begin
                out_d    = skid_q;
                out_v_d  = 1'b1;
                skid_v_d = 1'b0;
            end else begin
                out_v_d = in_fire;
                if (in_fire) begin
                    out_d = in_data;
                end
            end
        end else if (in_fire) begin
            skid_d   = in_data;
            skid_v_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= '0;
            skid_q <= '0;
            out_v  <= 1'b0;
            skid_v <= 1'b0;
            rdy_q  <= 1'b0;
        end else begin
            out_q  <= out_d;
            skid_q <= skid_d;
            out_v  <= out_v_d;
            skid_v <= skid_v_d;
            rdy_q  <= !skid_v_d;
        end
    end

    assign in_ready  = rdy_q;
    assign out_valid = out_v;
    assign out_data  = out_q;

endmodule

// File: rtl/imm_extend_pipe.sv
// rtl/imm_extend_pipe.sv - pipelined immediate extender; IMM_EXTEND_STATS_EN adds err_count/err_clr
module imm_extend_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [24:0]      in_instr,
    input  logic [2:0]       in_imm_src,
    input  logic [TAG_W-1:0] in_tag,
`ifdef IMM_EXTEND_STATS_EN
    input  logic             err_clr,
    output logic [31:0]      err_count,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);

    localparam int PW = XLEN + TAG_W + 1;

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("imm_extend_pipe: XLEN must be 32 or 64");
        end
    endgenerate

    logic [64:0]   ext;
    logic [PW-1:0] in_data, out_data;

    assign ext     = imm_extend(in_instr, imm_src_e'(in_imm_src), XLEN);
    assign in_data = {ext[64], ext[XLEN-1:0], in_tag};

    generate
        if (XLEN < 64) begin : g_narrow
            logic unused_hi;
            assign unused_hi = ^ext[63:XLEN];
        end
    endgenerate

    imm_skid_buf #(.W(PW)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    assign {out_err, out_imm, out_tag} = out_data;

`ifdef IMM_EXTEND_STATS_EN
    // Counts errored entries as they leave; clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (err_clr) begin
            err_count <= '0;
        end else if (out_valid && out_ready && out_err && (err_count != '1)) begin
            err_count <= err_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb/tb_imm_extend_pipe.sv - directed and random checks of imm_extend_pipe at XLEN 32 and 64
module tb_imm_extend_pipe;

    logic        clk, rst_n;
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_err;
    logic [24:0] a_in_instr;
    logic [2:0]  a_in_src;
    logic [3:0]  a_in_tag, a_out_tag;
    logic [31:0] a_out_imm;
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_err;
    logic [24:0] b_in_instr;
    logic [2:0]  b_in_src;
    logic [3:0]  b_in_tag, b_out_tag;
    logic [63:0] b_out_imm;
`ifdef IMM_EXTEND_STATS_EN
    logic        a_err_clr, b_err_clr;
    logic [31:0] a_err_count, b_err_count;
`endif

    int vectors = 0;
    int miscompares = 0;

    imm_extend_pipe #(.XLEN(32), .TAG_W(4)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_instr(a_in_instr),
        .in_imm_src(a_in_src), .in_tag(a_in_tag),
`ifdef IMM_EXTEND_STATS_EN
        .err_clr(a_err_clr), .err_count(a_err_count),
`endif
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_imm(a_out_imm),
        .out_tag(a_out_tag), .out_err(a_out_err)
    );

    imm_extend_pipe #(.XLEN(64), .TAG_W(4)) dut64 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_instr(b_in_instr),
        .in_imm_src(b_in_src), .in_tag(b_in_tag),
`ifdef IMM_EXTEND_STATS_EN
        .err_clr(b_err_clr), .err_count(b_err_count),
`endif
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_imm(b_out_imm),
        .out_tag(b_out_tag), .out_err(b_out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [64:0] ref_ext(input logic [31:7] ir, input logic [2:0] src,
                                            input int xl);
        case (src)
            3'd0:    ref_ext = {1'b0, {52{ir[31]}}, ir[31:20]};
            3'd1:    ref_ext = {1'b0, {52{ir[31]}}, ir[31:25], ir[11:7]};
            3'd2:    ref_ext = {1'b0, {52{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
            3'd3:    ref_ext = {1'b0, {44{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
            3'd4:    ref_ext = {1'b0, {32{ir[31]}}, ir[31:12], 12'h000};
            3'd5:    ref_ext = (xl == 64) ? {1'b0, 58'd0, ir[25:20]} : {1'b0, 59'd0, ir[24:20]};
            3'd6:    ref_ext = {1'b0, 59'd0, ir[19:15]};
            default: ref_ext = {1'b1, 64'd0};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_a(input logic [31:0] ir, input logic [2:0] src, input logic [3:0] tag);
        a_in_valid = 1'b1;
        a_in_instr = ir[31:7];
        a_in_src   = src;
        a_in_tag   = tag;
    endtask

    task automatic step_a(input string nm, input logic [31:0] ir, input logic [2:0] src,
                          input logic [31:0] exp_imm, input logic exp_err);
        a_out_ready = 1'b1;
        drive_a(ir, src, 4'h5);
        tick();
        a_in_valid = 1'b0;
        chk({nm, ".valid"}, 64'(a_out_valid), 64'd1);
        chk(nm, 64'(a_out_imm), 64'(exp_imm));
        chk({nm, ".err"}, 64'(a_out_err), 64'(exp_err));
    endtask

    task automatic step_b(input string nm, input logic [31:0] ir, input logic [2:0] src,
                          input logic [63:0] exp_imm);
        b_out_ready = 1'b1;
        b_in_valid  = 1'b1;
        b_in_instr  = ir[31:7];
        b_in_src    = src;
        b_in_tag    = 4'h6;
        tick();
        b_in_valid = 1'b0;
        chk({nm, ".valid"}, 64'(b_out_valid), 64'd1);
        chk(nm, b_out_imm, exp_imm);
        chk({nm, ".tag"}, 64'(b_out_tag), 64'h6);
    endtask

    initial begin
        logic [31:0] rir;
        logic [2:0]  rsrc;
        logic [3:0]  rtag;
        logic [64:0] r;
        logic [36:0] e;
        logic [36:0] q[$];
        int          sent;

        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in_instr = '0; a_in_src = '0; a_in_tag = '0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_instr = '0; b_in_src = '0; b_in_tag = '0; b_out_ready = 1'b0;
`ifdef IMM_EXTEND_STATS_EN
        a_err_clr = 1'b0;
        b_err_clr = 1'b0;
`endif
        #12;
        chk("rst.out_valid", 64'(a_out_valid), 64'd0);
        chk("rst.out_imm", 64'(a_out_imm), 64'd0);
        chk("rst.out_tag", 64'(a_out_tag), 64'd0);
        chk("rst.out_err", 64'(a_out_err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rst.in_ready32", 64'(a_in_ready), 64'd1);
        chk("rst.in_ready64", 64'(b_in_ready), 64'd1);

        step_a("i32", 32'hFFF0_0000, 3'd0, 32'hFFFF_FFFF, 1'b0);
        step_a("b32", 32'h0000_0863, 3'd2, 32'h0000_0010, 1'b0);
        step_a("s32", 32'h8000_0080, 3'd1, 32'hFFFF_F801, 1'b0);
        step_a("j32", 32'h0010_0000, 3'd3, 32'h0000_0800, 1'b0);
        step_a("u32", 32'h1234_5000, 3'd4, 32'h1234_5000, 1'b0);
        step_a("shamt32", 32'h03F0_0000, 3'd5, 32'h0000_001F, 1'b0);
        step_a("zimm32", 32'h000F_8000, 3'd6, 32'h0000_001F, 1'b0);
        step_a("rsvd32", 32'hFFFF_FFFF, 3'd7, 32'h0000_0000, 1'b1);

        step_b("u64", 32'h8000_0000, 3'd4, 64'hFFFF_FFFF_8000_0000);
        step_b("shamt64", 32'h03F0_0000, 3'd5, 64'h0000_0000_0000_003F);
        tick();
        chk("hold64.valid", 64'(b_out_valid), 64'd0);
        chk("hold64.imm", b_out_imm, 64'h3F);

        // Back-pressure: output stalled, second entry lands in skid, third is refused.
        a_out_ready = 1'b0;
        tick();
        drive_a(32'h0010_0000, 3'd0, 4'd1);
        tick();
        chk("bp.ready_after1", 64'(a_in_ready), 64'd1);
        drive_a(32'h0020_0000, 3'd0, 4'd2);
        tick();
        chk("bp.ready_after2", 64'(a_in_ready), 64'd0);
        chk("bp.tag_hold1", 64'(a_out_tag), 64'd1);
        drive_a(32'h0030_0000, 3'd0, 4'd3);
        tick();
        chk("bp.ready_stall", 64'(a_in_ready), 64'd0);
        chk("bp.tag_hold2", 64'(a_out_tag), 64'd1);
        chk("bp.valid_hold", 64'(a_out_valid), 64'd1);
        a_out_ready = 1'b1;
        tick();
        chk("bp.out2", 64'(a_out_tag), 64'd2);
        chk("bp.ready_rise", 64'(a_in_ready), 64'd1);
        tick();
        chk("bp.out3", 64'(a_out_tag), 64'd3);
        chk("bp.imm3", 64'(a_out_imm), 64'd3);
        for (int t = 4; t < 8; t++) begin
            drive_a({12'(t), 20'h0}, 3'd0, 4'(t));
            tick();
            chk("bp.stream_tag", 64'(a_out_tag), 64'(t));
            chk("bp.stream_valid", 64'(a_out_valid), 64'd1);
        end
        a_in_valid = 1'b0;
        tick();
        chk("bp.drained", 64'(a_out_valid), 64'd0);

        // Reset with both entries occupied.
        a_out_ready = 1'b0;
        drive_a(32'h0090_0000, 3'd0, 4'd9);
        tick();
        drive_a(32'h00A0_0000, 3'd0, 4'd10);
        tick();
        a_in_valid = 1'b0;
        chk("mrst.skid_full", 64'(a_in_ready), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst.valid", 64'(a_out_valid), 64'd0);
        chk("mrst.imm", 64'(a_out_imm), 64'd0);
        chk("mrst.tag", 64'(a_out_tag), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("mrst.in_ready", 64'(a_in_ready), 64'd1);
        a_out_ready = 1'b1;
        drive_a(32'hABC0_0000, 3'd0, 4'd11);
        tick();
        a_in_valid = 1'b0;
        chk("mrst.first_valid", 64'(a_out_valid), 64'd1);
        chk("mrst.first_imm", 64'(a_out_imm), 64'hFFFF_FABC);
        chk("mrst.first_tag", 64'(a_out_tag), 64'd11);
        tick();
        chk("mrst.no_stale", 64'(a_out_valid), 64'd0);

`ifdef IMM_EXTEND_STATS_EN
        for (int i = 0; i < 3; i++) begin
            drive_a(32'h1234_5678, 3'd7, 4'(i));
            tick();
        end
        a_in_valid = 1'b0;
        tick();
        chk("stats.count3", 64'(a_err_count), 64'd3);
        drive_a(32'h8765_4321, 3'd7, 4'd0);
        tick();
        a_in_valid = 1'b0;
        a_err_clr  = 1'b1;
        tick();
        a_err_clr = 1'b0;
        chk("stats.clr_wins", 64'(a_err_count), 64'd0);
`endif

        // Random valid/ready traffic against the reference model.
        sent = 0;
        for (int c = 0; c < 60000 && sent < 10000; c++) begin
            a_out_ready = 1'($urandom_range(0, 1));
            if (a_out_valid && a_out_ready) begin
                if (q.size() == 0) begin
                    chk("rnd.unexpected", 64'(a_out_valid), 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("rnd.entry", 64'({a_out_err, a_out_imm, a_out_tag}), 64'(e));
                end
            end
            rir  = $urandom;
            rsrc = 3'($urandom_range(0, 7));
            rtag = 4'($urandom_range(0, 15));
            drive_a(rir, rsrc, rtag);
            a_in_valid = 1'($urandom_range(0, 1));
            if (a_in_valid && a_in_ready) begin
                r = ref_ext(rir[31:7], rsrc, 32);
                q.push_back({r[64], r[31:0], rtag});
                sent++;
            end
            tick();
        end
        chk("rnd.sent", 64'(sent), 64'd10000);
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (a_out_valid) begin
                if (q.size() == 0) begin
                    chk("rnd.extra", 64'(a_out_valid), 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("rnd.drain_entry", 64'({a_out_err, a_out_imm, a_out_tag}), 64'(e));
                end
            end
            tick();
        end
        chk("rnd.queue_empty", 64'(q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
Parametrised, pipelined successor to the single-cycle immediate extender. It accepts instruction fields plus an immediate-format select over a valid/ready handshake. It produces the XLEN-wide extended immediate one cycle later, with a 2-entry skid buffer so decode back-pressure never drops data. It sits between the fetch/decode register and the execute operand mux, and adds U, shift-amount and CSR-zimm formats plus reserved-code error flagging.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64; immediates sign/zero-extended to XLEN.
TAG_W, 4, width of a sideband tag (ROB index/PC tag) carried alongside each immediate.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream entry valid
in_ready  output  1  block can accept an entry this cycle
in_instr  input  25  instruction bits [31:7]
in_imm_src  input  3  format select (see Behaviour)
in_tag  input  TAG_W  sideband tag
out_valid  output  1  out_imm/out_tag/out_err valid
out_ready  input  1  downstream accepts this cycle
out_imm  output  XLEN  extended immediate
out_tag  output  TAG_W  tag of out_imm
out_err  output  1  entry used reserved format code

Behaviour:
- Reset (async assert, sync release on clk): out_valid=0, skid entry empty, out_imm=0, out_tag=0, out_err=0, in_ready=1 one cycle after release.
- Format select; s = in_instr[31] replicated to fill XLEN:
  000 I: s, instr[31:20].
  001 S: s, instr[31:25], instr[11:7].
  010 B: s, instr[7], instr[30:25], instr[11:8], 0.
  011 J: s, instr[19:12], instr[20], instr[30:21], 0.
  100 U: s above bit 31 (XLEN=64 only), instr[31:12], 12'b0.
  101 SHAMT: zero-extended instr[20+log2(XLEN)-1:20] (5 bits for XLEN=32, 6 bits for XLEN=64).
  110 ZIMM: zero-extended instr[19:15].
  111 reserved: imm=0, err=1.
- Extension is combinational into the stage register. All other codes give err=0.
- Handshake:
  - Transfer occurs when valid&&ready on a side. Data is held stable while out_valid && !out_ready.
  - in_ready = !skid_full, registered; it depends on no input combinationally.
  - Latency: 1 cycle from input transfer to out_valid when the output register is empty or draining.
- Skid operation:
  - Input accepted while the output register holds an unaccepted entry: the entry goes to skid; in_ready drops next cycle.
  - Output accepted while skid full: skid moves to output the same cycle; in_ready rises next cycle.
  - Simultaneous input and output transfer with skid empty: new entry loads the output register; out_valid stays 1; throughput is 1/cycle.
  - Simultaneous input and output transfer with skid full cannot occur, because in_ready=0.
- Order is strictly preserved. No entry is dropped or duplicated.
- in_valid=0 while in_ready=1: no state change. Outputs hold their last values when out_valid=0.
- Reset mid-operation: both entries are discarded immediately and the block returns to reset values.
- XLEN other than 32/64: elaboration-time error via a generate-time assertion.

Optional Feature:
- Macro: IMM_EXTEND_STATS_EN.
- With the macro defined: adds output err_count (32 bits, reset 0). It increments by 1 on each output transfer with out_err=1 and saturates at all-ones.
- Also adds input err_clr (1 bit), a synchronous clear. err_clr has priority over a same-cycle increment.
- Without the macro: no ports, no counter, and identical datapath behaviour.

Decomposition:
- Package imm_pkg:
  - enum imm_src_e (IMM_I, IMM_S, IMM_B, IMM_J, IMM_U, IMM_SHAMT, IMM_ZIMM, IMM_RSVD), 3 bits.
  - A pure function imm_extend(instr, src, xlen) returning {err, imm}.
- Sub-module imm_skid_buf: 2-entry generic skid buffer, parametrised on payload width (XLEN+TAG_W+1).
- The top level is the function call feeding imm_skid_buf.

Test Plan:
- XLEN=32, I format, instr[31:20]=0xFFF, out_ready=1 -> next cycle out_imm=0xFFFFFFFF, err=0. Repeat with B format, instr=0x00000863 bits -> out_imm=0x00000010.
- XLEN=64, U format, instr[31:12]=0x80000 -> out_imm=0xFFFFFFFF80000000. SHAMT with instr[25:20]=0x3F -> out_imm=0x3F.
- Back-pressure:
  - Stream tags 1,2,3 with out_ready=0 -> in_ready=0 after tag 2 is accepted, tag 3 is held upstream.
  - Raise out_ready -> outputs in order 1,2,3 with no loss; steady state is 1 transfer/cycle.
- Code 111 with arbitrary instr -> out_imm=0, out_err=1. With IMM_EXTEND_STATS_EN: three such transfers give err_count=3; err_clr with a simultaneous error transfer gives err_count=0.
- Assert rst_n mid-stream with the skid full -> out_valid=0 and out_imm=0 immediately (asynchronously). After release, in_ready=1 and the first new entry appears with 1-cycle latency.
- Random valid/ready toggling over 10k entries against the imm_extend reference function -> zero mismatches, order preserved.
